alu_fault_monitor: RTL

Downstream consumer of the redundant dual-ALU comparator stage: samples the two ALU results, the carry outputs and the comparator flags every enabled cycle, and counts mismatches. It filters transient mismatches through a run-length state machine and latches a snapshot of the first persistent fault. Faults raise a user interrupt, and all state is exposed to the management core through a Wishbone slave register file. It sits in the user project wrapper between the ALU pair and `user_irq` / Wishbone.

---
 rtl/alu_mon_pkg.sv | 48 ++++
 rtl/alu_mon_wb_regs.sv | 86 ++++++++
 rtl/alu_fault_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the dual-ALU fault monitor: register map, FSM states,
// CTRL reset value and snapshot field layout.
package alu_mon_pkg;

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_COUNT  = 2'd2;
    localparam logic [1:0] ADR_SNAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    // enable=1, irq_en=1, threshold=1
    localparam logic [31:0] CTRL_RST = 32'h0000_0013;

    localparam int SNAP_TS_LSB   = 16;
    localparam int SNAP_ALU1_LSB = 11;
    localparam int SNAP_ALU2_LSB = 7;
    localparam int SNAP_C1_BIT   = 6;
    localparam int SNAP_C2_BIT   = 5;
    localparam int SNAP_CMPX_LSB = 1;
    localparam int SNAP_CMPY_BIT = 0;

    function automatic logic [31:0] pack_snap(
        input logic [15:0] ts,
        input logic [3:0]  alu1,
        input logic [3:0]  alu2,
        input logic        c1,
        input logic        c2,
        input logic [3:0]  cmpx,
        input logic        cmpy
    );
        logic [31:0] s;
        s = '0;
        s[SNAP_TS_LSB +: 16]  = ts;
        s[SNAP_ALU1_LSB +: 4] = alu1;
        s[SNAP_ALU2_LSB +: 4] = alu2;
        s[SNAP_C1_BIT]        = c1;
        s[SNAP_C2_BIT]        = c2;
        s[SNAP_CMPX_LSB +: 4] = cmpx;
        s[SNAP_CMPY_BIT]      = cmpy;
        return s;
    endfunction

endpackage

// File: rtl/alu_mon_wb_regs.sv
// Wishbone slave for the fault monitor: single-cycle ack, CTRL storage,
// registered read mux and the STATUS clear pulse.
module alu_mon_wb_regs
    import alu_mon_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [7:0]  dat_i,
    input  logic [7:0]  status_i,
    input  logic [31:0] count_i,
    input  logic [31:0] snap_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        enable_o,
    output logic        irq_en_o,
    output logic [3:0]  threshold_o,
    output logic        clr_o
);

    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic [3:0]  thr_q, thr_d;
    logic        req;
    logic        unused_dat;

    // A request is only accepted while ack is low, so held requests complete every other cycle.
    assign req        = stb_i & cyc_i & ~ack_q;
    assign unused_dat = ^dat_i[3:2];

    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        rdata    = '0;
        clr_o    = 1'b0;

        case (adr_i)
            ADR_CTRL:   rdata = {24'd0, thr_q, 2'b00, irq_en_q, enable_q};
            ADR_STATUS: rdata = {24'd0, status_i};
            ADR_COUNT:  rdata = count_i;
            default:    rdata = snap_i;
        endcase

        if (req && we_i) begin
            if (adr_i == ADR_CTRL) begin
                enable_d = dat_i[0];
                irq_en_d = dat_i[1];
                thr_d    = dat_i[7:4];
            end else if (adr_i == ADR_STATUS) begin
                clr_o = dat_i[0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            enable_q <= CTRL_RST[0];
            irq_en_q <= CTRL_RST[1];
            thr_q    <= CTRL_RST[7:4];
        end else begin
            ack_q    <= req;
            if (req) begin
                dat_q <= rdata;
            end
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
        end
    end

    assign ack_o       = ack_q;
    assign dat_o       = dat_q;
    assign enable_o    = enable_q;
    assign irq_en_o    = irq_en_q;
    assign threshold_o = thr_q;

endmodule

// File: rtl/alu_fault_monitor.sv
// Redundant-ALU mismatch monitor: run-length fault filter, saturating mismatch
// counter, first-fault snapshot, interrupt and Wishbone register access.
//
// state   | meaning
// IDLE    | no mismatch run in progress
// SUSPECT | consecutive enabled mismatches seen, below threshold
// FAULT   | persistent fault latched until cleared through STATUS
module alu_fault_monitor
    import alu_mon_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TS_W  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        sample_en,
    input  logic [3:0]  alu_out1,
    input  logic [3:0]  alu_out2,
    input  logic        carry1,
    input  logic        carry2,
    input  logic [3:0]  cmp_x,
    input  logic        cmp_y,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    state_e             state_q, state_d;
    logic [3:0]         run_q, run_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        snap_q, snap_d;
    logic [TS_W-1:0]    ts_q;
    logic               irq_q;

    logic               enable, irq_en, clr;
    logic [3:0]         threshold, thr_eff;
    logic               sampled, mm, clean;
    logic [4:0]         run_inc;
    logic [7:0]         status;
    logic [31:0]        snap_now;
    logic               unused_wb;

    assign unused_wb = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:8]};

    alu_mon_wb_regs u_regs (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .stb_i       (wbs_stb_i),
        .cyc_i       (wbs_cyc_i),
        .we_i        (wbs_we_i),
        .adr_i       (wbs_adr_i[3:2]),
        .dat_i       (wbs_dat_i[7:0]),
        .status_i    (status),
        .count_i     (32'(count_q)),
        .snap_i      (snap_q),
        .ack_o       (wbs_ack_o),
        .dat_o       (wbs_dat_o),
        .enable_o    (enable),
        .irq_en_o    (irq_en),
        .threshold_o (threshold),
        .clr_o       (clr)
    );

    assign thr_eff  = (threshold == 4'd0) ? 4'd1 : threshold;
    assign sampled  = sample_en & enable;
    assign mm       = sampled & ((|cmp_x) | cmp_y);
    assign clean    = sampled & ~((|cmp_x) | cmp_y);
    assign run_inc  = {1'b0, run_q} + 5'd1;
    assign status   = {run_q, ovf_q, (state_q == ST_FAULT), state_q};
    assign snap_now = pack_snap(16'(ts_q), alu_out1, alu_out2, carry1, carry2, cmp_x, cmp_y);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        snap_d  = snap_q;

        case (state_q)
            ST_IDLE: begin
                if (mm) begin
                    run_d = 4'd1;
                    if (thr_eff <= 4'd1) begin
                        state_d = ST_FAULT;
                        snap_d  = snap_now;
                    end else begin
                        state_d = ST_SUSPECT;
                    end
                end
            end
            ST_SUSPECT: begin
                if (mm) begin
                    run_d = run_inc[3:0];
                    // >= so a threshold lowered below the current run trips on the next mismatch
                    if (run_inc >= {1'b0, thr_eff}) begin
                        state_d = ST_FAULT;
                        snap_d  = snap_now;
                    end
                end else if (clean) begin
                    state_d = ST_IDLE;
                    run_d   = 4'd0;
                end
            end
            default: ;
        endcase

        if (mm) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (clr) begin
            state_d = ST_IDLE;
            run_d   = 4'd0;
            count_d = '0;
            ovf_d   = 1'b0;
            snap_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            run_q   <= 4'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            snap_q  <= '0;
            ts_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            snap_q  <= snap_d;
            ts_q    <= ts_q + TS_W'(1);
            irq_q   <= (state_q == ST_FAULT) & irq_en;
        end
    end

    assign irq_o = irq_q;

endmodule
